// File: rtl/alu_exec_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared types and constants for the execute sequencer, the alu and its bench.
// Contents: sequencer state enum, command-kind enum, ALU op codes, and a
// helper that tells whether a command kind needs a pass through the ALU.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    WB   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_MULT = 2'b01,
    KIND_MFHI = 2'b10,
    KIND_MFLO = 2'b11
  } cmd_kind_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_MULT  = 4'd9;
  localparam logic [3:0] ALU_MULTU = 4'd10;

  // Kinds 00/01 read operands and run the ALU; MFHI/MFLO go straight to WB.
  function automatic logic kindUsesAlu(cmd_kind_t kind);
    return (kind == KIND_ALU) || (kind == KIND_MULT);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if
// Bundles every non-clock/reset signal of the execute sequencer: command
// handshake, register-file read/write ports, ALU drive/result, and status.
// Modports:
//   master - the sequencer side (drives ready, rf/alu requests, status)
//   slave  - the surroundings (decode, regfile, alu)
// ADDR_W/DATA_W must match the parameters of the alu_exec_ctrl instance.
interface alu_exec_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs;
  logic [ADDR_W-1:0] cmd_rt;
  logic [ADDR_W-1:0] cmd_rd;
  logic [4:0]        cmd_shamt;

  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [4:0]        alu_shamt;
  logic [DATA_W-1:0] alu_hi;
  logic [DATA_W-1:0] alu_lo;
  logic              alu_zero;

  logic              done;
  logic              zero_flag;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  modport master (
    input  cmd_valid, cmd_kind, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
    input  rf_rdata1, rf_rdata2, alu_hi, alu_lo, alu_zero,
    output cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    output alu_a, alu_b, alu_op, alu_shamt, done, zero_flag, hi_q, lo_q
  );

  modport slave (
    output cmd_valid, cmd_kind, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
    output rf_rdata1, rf_rdata2, alu_hi, alu_lo, alu_zero,
    input  cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    input  alu_a, alu_b, alu_op, alu_shamt, done, zero_flag, hi_q, lo_q
  );

endinterface

// File: rtl/alu_exec_ctrl_hilo_reg.sv
// hilo_reg
// The HI/LO result pair written by multiply-class commands.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset (clears both to 0)
//   we_i           - load hi_i/lo_i on the next rising edge
//   hi_i, lo_i     - new HI/LO values
//   hi_o, lo_o     - current HI/LO contents
module hilo_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Both halves always load together so HI/LO never disagree about which
  // multiply they came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we_i) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Multi-cycle execute sequencer between the register file and the shared,
// purely combinational alu. Takes one command at a time, reads two sources,
// drives the ALU and writes the result to the regfile or to HI/LO.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - alu_exec_ctrl_if.master: command handshake, regfile
//                read/write, ALU drive/result, done/zero_flag/hi_q/lo_q
// Flow: IDLE -> READ -> EXEC -> WB for kinds 00/01, IDLE -> WB for MFHI/MFLO.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_ctrl_if.master bus
);

  state_t            state_q, state_d;
  cmd_kind_t         kind_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [4:0]        shamt_q;
  logic [DATA_W-1:0] opA_q, opB_q;
  logic [DATA_W-1:0] aluHi_q, aluLo_q;
  logic              aluZero_q;
  logic              zeroFlag_q;
  logic              hiloWe;
  logic [DATA_W-1:0] hiVal, loVal;

  // State register plus the per-phase capture registers. Command fields are
  // latched at accept so the decoder may change them immediately afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kind_q     <= KIND_ALU;
      op_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      shamt_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      aluHi_q    <= '0;
      aluLo_q    <= '0;
      aluZero_q  <= 1'b0;
      zeroFlag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            kind_q  <= cmd_kind_t'(bus.cmd_kind);
            op_q    <= bus.cmd_op;
            rs_q    <= bus.cmd_rs;
            rt_q    <= bus.cmd_rt;
            rd_q    <= bus.cmd_rd;
            shamt_q <= bus.cmd_shamt;
          end
        end
        READ: begin
          opA_q <= bus.rf_rdata1;
          opB_q <= bus.rf_rdata2;
        end
        EXEC: begin
          aluHi_q   <= bus.alu_hi;
          aluLo_q   <= bus.alu_lo;
          aluZero_q <= bus.alu_zero;
        end
        WB: begin
          if (kindUsesAlu(kind_q)) begin
            zeroFlag_q <= aluZero_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all state-derived outputs. rf_we/done depend only on
  // registered state, kind and rd, so they cannot glitch.
  always_comb begin
    state_d      = state_q;
    bus.rf_wdata = aluLo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = kindUsesAlu(cmd_kind_t'(bus.cmd_kind)) ? READ : WB;
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (kind_q)
      KIND_MFHI: bus.rf_wdata = hiVal;
      KIND_MFLO: bus.rf_wdata = loVal;
      default:   bus.rf_wdata = aluLo_q;
    endcase
  end

  // r0 is read-only, so a WB to rd==0 completes without a write strobe.
  assign hiloWe        = (state_q == WB) && (kind_q == KIND_MULT);
  assign bus.rf_we     = (state_q == WB) && (kind_q != KIND_MULT) && (rd_q != '0);
  assign bus.rf_waddr  = rd_q;
  assign bus.done      = (state_q == WB);
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rf_raddr1 = rs_q;
  assign bus.rf_raddr2 = rt_q;
  assign bus.alu_a     = opA_q;
  assign bus.alu_b     = opB_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_shamt = shamt_q;
  assign bus.zero_flag = zeroFlag_q;
  assign bus.hi_q      = hiVal;
  assign bus.lo_q      = loVal;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (hiloWe),
    .hi_i  (aluHi_q),
    .lo_i  (aluLo_q),
    .hi_o  (hiVal),
    .lo_o  (loVal)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl
// Bench for alu_exec_ctrl: supplies a behavioural regfile and ALU, issues
// directed and randomized commands, and compares every observable against a
// reference model of regfile/HI/LO/zero contents kept as plain arrays.
module tb_alu_exec_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   failCount = 0;

  logic [31:0] rf [32];
  logic        preloadEn;
  logic [4:0]  preloadAddr;
  logic [31:0] preloadData;

  logic [31:0] mRf [32];
  logic [31:0] mHi, mLo;
  logic        mZero;
  logic [63:0] aluRes;

  alu_exec_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  alu_exec_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {hi, lo} result of an op, computed at 64 bits.
  function automatic logic [63:0] aluRef(logic [3:0] op, logic [31:0] a,
                                          logic [31:0] b, logic [4:0] sh);
    logic [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      ALU_ADD:   return {32'd0, a + b};
      ALU_SUB:   return {32'd0, a - b};
      ALU_AND:   return {32'd0, a & b};
      ALU_OR:    return {32'd0, a | b};
      ALU_XOR:   return {32'd0, a ^ b};
      ALU_SLL:   return {32'd0, b << sh};
      ALU_SRL:   return {32'd0, b >> sh};
      ALU_SRA:   return {32'd0, 32'($signed(b) >>> sh)};
      ALU_SLT:   return 64'($signed(a) < $signed(b));
      ALU_MULT:  return sa * sb;
      ALU_MULTU: return {32'd0, a} * {32'd0, b};
      default:   return 64'd0;
    endcase
  endfunction

  // Environment: the regfile reads combinationally and writes on the edge,
  // either from the bench preload port or from the DUT write port.
  always @(posedge clk) begin
    if (preloadEn) rf[preloadAddr] <= preloadData;
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];
  assign aluRes        = aluRef(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
  assign bus.alu_hi    = aluRes[63:32];
  assign bus.alu_lo    = aluRes[31:0];
  assign bus.alu_zero  = (aluRes == 64'd0);

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Effect of one command on the architectural state.
  task automatic modelExec(input logic [1:0] kind, input logic [3:0] op,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh);
    logic [63:0] res;
    res = aluRef(op, mRf[rs], mRf[rt], sh);
    case (kind)
      2'b00: begin
        if (rd != 0) mRf[rd] = res[31:0];
        mZero = (res == 64'd0);
      end
      2'b01: begin
        mHi = res[63:32];
        mLo = res[31:0];
        mZero = (res == 64'd0);
      end
      2'b10: if (rd != 0) mRf[rd] = mHi;
      default: if (rd != 0) mRf[rd] = mLo;
    endcase
  endtask

  // Writes one register through the preload port; starts and ends on a negedge.
  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    preloadEn   = 1'b1;
    preloadAddr = addr;
    preloadData = data;
    mRf[addr]   = data;
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 64'(bus.cmd_ready), 64'(1));
  endtask

  task automatic driveFields(input logic [1:0] kind, input logic [3:0] op,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh);
    bus.cmd_kind  = kind;
    bus.cmd_op    = op;
    bus.cmd_rs    = rs;
    bus.cmd_rt    = rt;
    bus.cmd_rd    = rd;
    bus.cmd_shamt = sh;
  endtask

  // Issues one command at the current negedge and checks every cycle up to
  // and including the return to IDLE. Ends on a negedge with the DUT idle.
  task automatic applyStimulus(input logic [1:0] kind, input logic [3:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh);
    logic [63:0] res;
    logic [31:0] expWdata;
    logic        expWe;
    int          lat;
    waitIdle();
    res      = aluRef(op, mRf[rs], mRf[rt], sh);
    lat      = (kind < 2) ? 3 : 1;
    expWe    = (kind != 2'b01) && (rd != 0);
    expWdata = (kind == 2'b10) ? mHi : (kind == 2'b11) ? mLo : res[31:0];
    driveFields(kind, op, rs, rt, rd, sh);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    driveFields(2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom));
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      checkOutput("ready_busy", 64'(bus.cmd_ready), 64'(0));
      if (kind < 2 && c == 1) begin
        checkOutput("raddr1", 64'(bus.rf_raddr1), 64'(rs));
        checkOutput("raddr2", 64'(bus.rf_raddr2), 64'(rt));
      end
      if (kind < 2 && c == 2) begin
        checkOutput("alu_a", 64'(bus.alu_a), 64'(mRf[rs]));
        checkOutput("alu_b", 64'(bus.alu_b), 64'(mRf[rt]));
        checkOutput("alu_op", 64'(bus.alu_op), 64'(op));
        checkOutput("alu_shamt", 64'(bus.alu_shamt), 64'(sh));
      end
      if (c < lat) begin
        checkOutput("done_early", 64'(bus.done), 64'(0));
        checkOutput("we_early", 64'(bus.rf_we), 64'(0));
      end else begin
        checkOutput("done_wb", 64'(bus.done), 64'(1));
        checkOutput("we_wb", 64'(bus.rf_we), 64'(expWe));
        if (expWe) begin
          checkOutput("waddr", 64'(bus.rf_waddr), 64'(rd));
          checkOutput("wdata", 64'(bus.rf_wdata), 64'(expWdata));
        end
      end
    end
    modelExec(kind, op, rs, rt, rd, sh);
    @(negedge clk);
    checkOutput("done_after", 64'(bus.done), 64'(0));
    checkOutput("ready_after", 64'(bus.cmd_ready), 64'(1));
    checkOutput("hi_q", 64'(bus.hi_q), 64'(mHi));
    checkOutput("lo_q", 64'(bus.lo_q), 64'(mLo));
    checkOutput("zero_flag", 64'(bus.zero_flag), 64'(mZero));
  endtask

  task automatic checkRegfile(input string tag);
    for (int i = 0; i < 32; i++) checkOutput(tag, 64'(rf[i]), 64'(mRf[i]));
  endtask

  // cmd_valid stays high with new fields every cycle; only the commands
  // present while the DUT is idle may take effect.
  task automatic heldValidTest();
    int       busyLeft = 0;
    logic [1:0] k;
    logic [3:0] op;
    logic [4:0] rs, rt, rd, sh;
    for (int i = 0; i < 10; i++) begin
      k  = 2'($urandom_range(0, 3));
      op = 4'($urandom_range(0, 10));
      rs = 5'($urandom);
      rt = 5'($urandom);
      rd = 5'($urandom);
      sh = 5'($urandom);
      driveFields(k, op, rs, rt, rd, sh);
      bus.cmd_valid = 1'b1;
      checkOutput("held_ready", 64'(bus.cmd_ready), 64'(busyLeft == 0));
      if (busyLeft == 0) begin
        modelExec(k, op, rs, rt, rd, sh);
        busyLeft = (k < 2) ? 3 : 1;
      end else begin
        busyLeft--;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    waitIdle();
    checkRegfile("held_rf");
    checkOutput("held_hi", 64'(bus.hi_q), 64'(mHi));
    checkOutput("held_lo", 64'(bus.lo_q), 64'(mLo));
    checkOutput("held_zero", 64'(bus.zero_flag), 64'(mZero));
  endtask

  // Aborts add r6=r1+r2 during EXEC; nothing may be written and HI/LO clear.
  task automatic resetMidExec();
    waitIdle();
    driveFields(2'b00, ALU_ADD, 5'd1, 5'd2, 5'd6, 5'd0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", 64'(bus.rf_we), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_hi", 64'(bus.hi_q), 64'(0));
    checkOutput("rst_lo", 64'(bus.lo_q), 64'(0));
    mHi = '0;
    mLo = '0;
    mZero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready", 64'(bus.cmd_ready), 64'(1));
    checkOutput("rel_we", 64'(bus.rf_we), 64'(0));
    checkOutput("rel_zero", 64'(bus.zero_flag), 64'(0));
    checkOutput("rel_alu_a", 64'(bus.alu_a), 64'(0));
    checkOutput("rel_raddr1", 64'(bus.rf_raddr1), 64'(0));
    checkOutput("rel_wdata", 64'(bus.rf_wdata), 64'(0));
    checkOutput("rel_r6", 64'(rf[6]), 64'(mRf[6]));
  endtask

  initial begin
    rst_n         = 1'b0;
    preloadEn     = 1'b0;
    preloadAddr   = '0;
    preloadData   = '0;
    bus.cmd_valid = 1'b0;
    driveFields(2'b00, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    mHi   = '0;
    mLo   = '0;
    mZero = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) preload(5'(i), (i == 0) ? 32'd0 : $urandom);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("init_ready", 64'(bus.cmd_ready), 64'(1));
    checkOutput("init_we", 64'(bus.rf_we), 64'(0));
    checkOutput("init_done", 64'(bus.done), 64'(0));
    checkOutput("init_zero", 64'(bus.zero_flag), 64'(0));
    checkOutput("init_hi", 64'(bus.hi_q), 64'(0));
    checkOutput("init_lo", 64'(bus.lo_q), 64'(0));
    checkOutput("init_alu_a", 64'(bus.alu_a), 64'(0));

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    applyStimulus(2'b00, ALU_ADD, 5'd1, 5'd2, 5'd3, 5'd0);
    checkOutput("add_r3", 64'(rf[3]), 64'h0000_000C);

    preload(5'd1, 32'hFFFF_FFFF);
    preload(5'd2, 32'd2);
    applyStimulus(2'b01, ALU_MULT, 5'd1, 5'd2, 5'd9, 5'd0);
    checkOutput("mult_hi", 64'(bus.hi_q), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(bus.lo_q), 64'hFFFF_FFFE);
    applyStimulus(2'b10, 4'd0, 5'd0, 5'd0, 5'd4, 5'd0);
    checkOutput("mfhi_r4", 64'(rf[4]), 64'hFFFF_FFFF);

    preload(5'd1, 32'h1234);
    preload(5'd2, 32'h1234);
    applyStimulus(2'b00, ALU_SUB, 5'd1, 5'd2, 5'd0, 5'd0);
    checkOutput("sub_zero", 64'(bus.zero_flag), 64'(1));
    checkOutput("r0_kept", 64'(rf[0]), 64'(0));

    preload(5'd2, 32'd1);
    applyStimulus(2'b00, ALU_SLL, 5'd0, 5'd2, 5'd5, 5'd31);
    checkOutput("sll_r5", 64'(rf[5]), 64'h8000_0000);
    applyStimulus(2'b11, 4'd0, 5'd0, 5'd0, 5'd7, 5'd0);
    checkOutput("mflo_r7", 64'(rf[7]), 64'hFFFF_FFFE);

    resetMidExec();
    heldValidTest();

    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    checkRegfile("final_rf");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute sequencer between the register file and the shared `alu`. Accepts one command at a time over a valid/ready handshake, reads two source registers, drives the ALU, and writes the result back to the register file or to internal HI/LO registers. Sits between instruction decode and the regfile/ALU pair; the ALU stays purely combinational.

## Interface
Parameters:
- `ADDR_W`, 5: register address width (32 registers).
- `DATA_W`, 32: datapath width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller idle and accepting.
- `cmd_kind`  in  2  00 ALU→rd, 01 ALU→HI/LO, 10 MFHI→rd, 11 MFLO→rd.
- `cmd_op`  in  4  ALU op code, passed to ALU unchanged.
- `cmd_rs`, `cmd_rt`, `cmd_rd`  in  ADDR_W each  source A, source B, destination.
- `cmd_shamt`  in  5  shift amount.
- `rf_raddr1`, `rf_raddr2`  out  ADDR_W  regfile read addresses (combinational read).
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  regfile read data.
- `rf_we`  out  1  regfile write enable.
- `rf_waddr`  out  ADDR_W; `rf_wdata`  out  DATA_W.
- `alu_a`, `alu_b`  out  DATA_W; `alu_op`  out  4; `alu_shamt`  out  5.
- `alu_hi`, `alu_lo`  in  DATA_W; `alu_zero`  in  1.
- `done`  out  1  one-cycle pulse on command completion.
- `zero_flag`  out  1  ALU zero of last ALU command.
- `hi_q`, `lo_q`  out  DATA_W  HI/LO register contents.

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`: latch kind/op/rs/rt/rd/shamt. Kind 00/01 → READ; kind 10/11 → WB.
- READ: `rf_raddr1`=rs, `rf_raddr2`=rt; capture `rf_rdata1/2` into operand registers → EXEC.
- EXEC: `alu_a/b/op/shamt` driven from operand/command registers; capture `alu_hi`, `alu_lo`, `alu_zero` → WB.
- WB, kind 00: `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=captured lo; `zero_flag` updated.
- WB, kind 01: HI←captured hi, LO←captured lo; `rf_we`=0; `zero_flag` updated.
- WB, kind 10/11: `rf_we`=1, `rf_wdata`=`hi_q`/`lo_q`; `zero_flag` unchanged.
- rd==0 in WB: `rf_we` held 0 (r0 read-only); `done` still pulses.
- WB → IDLE always; `done`=1 during WB.
- Undefined op codes are passed through; the controller does not decode `cmd_op`.
- `rf_raddr*`, `alu_*` outputs are don't-care outside READ/EXEC but must be driven from registers (no X).

## Timing
- Accept edge = cycle N. Kinds 00/01: READ N+1, EXEC N+2, WB N+3 (`done`, `rf_we` high during N+3). Kinds 10/11: WB N+1.
- `cmd_ready` high only in IDLE; earliest next accept is cycle after WB (throughput 1 per 4 or 2 cycles).
- MFHI/MFLO issued immediately after a kind-01 command sees the new HI/LO (updated at WB edge).
- `rf_we` is combinational from state, glitch-free (registered state, registered kind/rd).
- Reset (any state, including mid-command): state→IDLE, command aborted with no write, `cmd_ready`=1 after release, `rf_we`=0, `done`=0, `zero_flag`=0, `hi_q`=`lo_q`=0, all address/data/alu outputs 0.
- `cmd_valid` while busy is ignored; command fields need not be held after accept.

## Structure
- Package `alu_ctrl_pkg`: state enum (IDLE/READ/EXEC/WB), `cmd_kind_t` enum (KIND_ALU, KIND_MULT, KIND_MFHI, KIND_MFLO), ALU op constants shared with `alu` and its bench.
- One sub-module natural: `hilo_reg` (two DATA_W registers, write enable, async active-low reset). FSM and operand registers stay in the top.

## Test plan
- Reset mid-EXEC of add r3=r1+r2 → no `rf_we`, `hi_q`/`lo_q`=0, `cmd_ready`=1 the cycle after `rst_n` rises.
- r1=5, r2=7, kind 00 op add rd=3 → `rf_we` at N+3, `rf_waddr`=3, `rf_wdata`=0x0000000C, `done` one cycle, `zero_flag`=0.
- r1=0xFFFFFFFF, r2=2, kind 01 signed mult → `hi_q`=0xFFFFFFFF, `lo_q`=0xFFFFFFFE at N+4, no `rf_we`; then MFHI rd=4 → `rf_wdata`=0xFFFFFFFF at N'+1.
- r1=r2=0x1234, kind 00 op sub rd=0 → `rf_we`=0, `done`=1, `zero_flag`=1.
- `cmd_valid` held high for 10 cycles with changing fields → exactly the commands seen at accept edges executed, `cmd_ready` low in READ/EXEC/WB.
- sll r2 (0x1) shamt=31 rd=5 → `rf_wdata`=0x80000000, `alu_shamt`=31 during EXEC.
